mac_tx_framer: RTL



---
 rtl/mac_tx_framer.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/mac_tx_framer.sv
// mac_tx_framer
//   Store-and-forward transmit framer feeding the RGMII MAC transmit channel.
//   Frames arrive as a ready/valid byte stream, are buffered in full, then
//   replayed to the MAC as one contiguous burst. Short frames are zero-padded
//   to MIN_LEN, frames longer than MAX_LEN are discarded, and IFG_CYCLES idle
//   cycles separate consecutive frames on the MAC side.
//
// Ports
//   mac_tx_clk   : single clock shared with the MAC transmit logic
//   rst          : synchronous, active-high reset
//   s_data/s_valid/s_last/s_ready : input byte stream (dest MAC .. payload)
//   mac_tx_data/valid/sof/eof     : registered byte burst to the MAC
//   drop_o       : one-cycle pulse when an oversize frame is discarded
//   tx_frames_o  : count of frames sent, wraps modulo 2^16
module mac_tx_framer #(
    parameter int unsigned DEPTH_LOG2 = 11,
    parameter int unsigned MIN_LEN    = 60,
    parameter int unsigned MAX_LEN    = 1514,
    parameter int unsigned IFG_CYCLES = 20
) (
    input  logic        mac_tx_clk,
    input  logic        rst,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    input  logic        s_last,
    output logic        s_ready,
    output logic [7:0]  mac_tx_data,
    output logic        mac_tx_valid,
    output logic        mac_tx_sof,
    output logic        mac_tx_eof,
    output logic        drop_o,
    output logic [15:0] tx_frames_o
);

    localparam int unsigned    PW         = DEPTH_LOG2 + 1;
    localparam logic [PW-1:0]  DEPTH_C    = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [PW-1:0]  READY_TH_C = PW'(MAX_LEN + 1);
    localparam logic [15:0]    MIN_C      = 16'(MIN_LEN);
    localparam logic [15:0]    MAX_C      = 16'(MAX_LEN);
    localparam logic [15:0]    MAXP1_C    = 16'(MAX_LEN + 1);
    localparam logic [15:0]    GAP_LAST_C = 16'(IFG_CYCLES - 2);

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_PAD, S_GAP} state_t;

    // {last, data} per byte
    logic [8:0] mem [0:(2**DEPTH_LOG2)-1];
    logic [8:0] ram_rdata_q;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] frame_start_q, frame_start_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] pending_q, pending_d;
    logic          in_frame_q, in_frame_d;
    logic [15:0]   len_q, len_d;
    state_t        state_q, state_d;
    logic [15:0]   sent_q, sent_d;
    logic [15:0]   gap_q, gap_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          tx_valid_q, tx_valid_d;
    logic          tx_sof_q, tx_sof_d;
    logic          tx_eof_q, tx_eof_d;
    logic          drop_q, drop_d;
    logic [15:0]   tx_frames_q, tx_frames_d;

    logic [PW-1:0] free;
    logic          accept, wr_en, rd_en, commit, start;
    logic [15:0]   len_inc, sent_next;

    assign free    = DEPTH_C - (wr_ptr_q - rd_ptr_q);
    assign s_ready = ~rst & (in_frame_q | (free >= READY_TH_C));
    assign accept  = s_valid & s_ready;
    assign wr_en   = accept & (len_q < MAX_C);
    assign len_inc = (len_q == MAXP1_C) ? len_q : len_q + 16'd1;

    // Write side: buffer bytes, commit or roll back on s_last.
    always_comb begin
        wr_ptr_d      = wr_ptr_q;
        frame_start_d = frame_start_q;
        in_frame_d    = in_frame_q;
        len_d         = len_q;
        drop_d        = 1'b0;
        commit        = 1'b0;
        if (accept) begin
            in_frame_d = 1'b1;
            len_d      = len_inc;
            if (wr_en) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (s_last) begin
                in_frame_d = 1'b0;
                len_d      = '0;
                if (len_inc <= MAX_C) begin
                    commit        = 1'b1;
                    frame_start_d = wr_ptr_q + 1'b1;
                end else begin
                    wr_ptr_d = frame_start_q;
                    drop_d   = 1'b1;
                end
            end
        end
    end

    // Read side. rd_ptr always names the next byte to fetch; the fetch for
    // byte n+1 is issued while byte n is being emitted, so bursts never stall.
    // GAP holds for IFG_CYCLES-1 cycles; the following IDLE cycle supplies the
    // last idle cycle on the output, giving exactly IFG_CYCLES idle cycles.
    always_comb begin
        state_d     = state_q;
        rd_ptr_d    = rd_ptr_q;
        sent_d      = sent_q;
        gap_d       = gap_q;
        rd_en       = 1'b0;
        start       = 1'b0;
        tx_data_d   = '0;
        tx_valid_d  = 1'b0;
        tx_sof_d    = 1'b0;
        tx_eof_d    = 1'b0;
        sent_next   = sent_q + 16'd1;
        unique case (state_q)
            S_IDLE: begin
                if (pending_q != '0) begin
                    rd_en    = 1'b1;
                    rd_ptr_d = rd_ptr_q + 1'b1;
                    start    = 1'b1;
                    sent_d   = '0;
                    state_d  = S_SEND;
                end
            end
            S_SEND: begin
                tx_valid_d = 1'b1;
                tx_data_d  = ram_rdata_q[7:0];
                tx_sof_d   = (sent_q == '0);
                sent_d     = sent_next;
                if (ram_rdata_q[8]) begin
                    if (sent_next < MIN_C) begin
                        state_d = S_PAD;
                    end else begin
                        tx_eof_d = 1'b1;
                        gap_d    = '0;
                        state_d  = S_GAP;
                    end
                end else begin
                    rd_en    = 1'b1;
                    rd_ptr_d = rd_ptr_q + 1'b1;
                end
            end
            S_PAD: begin
                tx_valid_d = 1'b1;
                sent_d     = sent_next;
                if (sent_next == MIN_C) begin
                    tx_eof_d = 1'b1;
                    gap_d    = '0;
                    state_d  = S_GAP;
                end
            end
            S_GAP: begin
                if (gap_q == GAP_LAST_C) begin
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q + 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        pending_d = pending_q;
        if (commit && !start) begin
            pending_d = pending_q + 1'b1;
        end else if (!commit && start) begin
            pending_d = pending_q - 1'b1;
        end

        tx_frames_d = tx_frames_q;
        if (tx_eof_d) begin
            tx_frames_d = tx_frames_q + 16'd1;
        end
    end

    always_ff @(posedge mac_tx_clk) begin
        if (wr_en) begin
            mem[wr_ptr_q[DEPTH_LOG2-1:0]] <= {s_last, s_data};
        end
        if (rd_en) begin
            ram_rdata_q <= mem[rd_ptr_q[DEPTH_LOG2-1:0]];
        end
    end

    always_ff @(posedge mac_tx_clk) begin
        if (rst) begin
            wr_ptr_q      <= '0;
            frame_start_q <= '0;
            rd_ptr_q      <= '0;
            pending_q     <= '0;
            in_frame_q    <= 1'b0;
            len_q         <= '0;
            state_q       <= S_IDLE;
            sent_q        <= '0;
            gap_q         <= '0;
            tx_data_q     <= '0;
            tx_valid_q    <= 1'b0;
            tx_sof_q      <= 1'b0;
            tx_eof_q      <= 1'b0;
            drop_q        <= 1'b0;
            tx_frames_q   <= '0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            frame_start_q <= frame_start_d;
            rd_ptr_q      <= rd_ptr_d;
            pending_q     <= pending_d;
            in_frame_q    <= in_frame_d;
            len_q         <= len_d;
            state_q       <= state_d;
            sent_q        <= sent_d;
            gap_q         <= gap_d;
            tx_data_q     <= tx_data_d;
            tx_valid_q    <= tx_valid_d;
            tx_sof_q      <= tx_sof_d;
            tx_eof_q      <= tx_eof_d;
            drop_q        <= drop_d;
            tx_frames_q   <= tx_frames_d;
        end
    end

    assign mac_tx_data  = tx_data_q;
    assign mac_tx_valid = tx_valid_q;
    assign mac_tx_sof   = tx_sof_q;
    assign mac_tx_eof   = tx_eof_q;
    assign drop_o       = drop_q;
    assign tx_frames_o  = tx_frames_q;

endmodule
